// File: rtl/float16_pkg.sv
// Shared constants, unpacked-operand type and operand decoder for the binary16 adder.
package float16_pkg;

  localparam int unsigned FLOAT_LEN = 16;
  localparam int unsigned EXP_LEN   = 5;
  localparam int unsigned MANT_LEN  = 10;
  localparam int unsigned BIAS      = 15;
  localparam int unsigned EXP_MAX   = 2 * BIAS + 1;

  localparam logic [FLOAT_LEN-1:0] QNAN    = 16'h7E00;
  localparam logic [FLOAT_LEN-1:0] POS_INF = 16'h7C00;
  localparam logic [FLOAT_LEN-1:0] NEG_INF = 16'hFC00;

  typedef struct packed {
    logic                sign;
    logic [EXP_LEN-1:0]  exp;
    logic [MANT_LEN:0]   sig;
    logic                is_nan;
    logic                is_inf;
    logic                is_zero;
  } operand_t;

  // Subnormals get effective exponent 1 and a zero hidden bit.
  function automatic operand_t unpack(input logic [FLOAT_LEN-1:0] x);
    operand_t o;
    logic     exp_zero;
    logic     exp_ones;
    exp_zero  = (x[14:10] == 5'd0);
    exp_ones  = (x[14:10] == 5'h1F);
    o.sign    = x[15];
    o.exp     = exp_zero ? 5'd1 : x[14:10];
    o.sig     = {~exp_zero, x[9:0]};
    o.is_nan  = exp_ones & (x[9:0] != 10'd0);
    o.is_inf  = exp_ones & (x[9:0] == 10'd0);
    o.is_zero = (x[14:0] == 15'd0);
    return o;
  endfunction

endpackage

// File: rtl/float16_lzc.sv
// Leading-zero count of a 14-bit value; an all-zero input counts 14.
module float16_lzc (
  input  logic [13:0] value,
  output logic [3:0]  count
);

  always_comb begin
    count = 4'd14;
    for (int i = 0; i < 14; i++) begin
      if (value[i]) count = 4'(13 - i);
    end
  end

endmodule

// File: rtl/float16_adder.sv
// Two-stage pipelined IEEE-754 binary16 adder, round-to-nearest-even.
module float16_adder #(
  parameter int unsigned FLOAT_LEN = 16,
  parameter int unsigned EXP_LEN   = 5,
  parameter int unsigned MANT_LEN  = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [FLOAT_LEN-1:0] a,
  input  logic [FLOAT_LEN-1:0] b,
  output logic [FLOAT_LEN-1:0] result
);
  import float16_pkg::*;

  localparam int unsigned SIG_LEN = MANT_LEN + 1;
  localparam int unsigned EXT_LEN = SIG_LEN + 3;

  logic [FLOAT_LEN-1:0] a_q, b_q;

  operand_t             ua, ub;
  logic                 a_larger;
  logic                 big_sign, sml_sign;
  logic [EXP_LEN-1:0]   big_exp, sml_exp, diff;
  logic [SIG_LEN-1:0]   big_sig, sml_sig;
  logic [EXT_LEN-1:0]   big_ext, sml_ext, sml_shift, lost_mask, aligned;
  logic                 sticky;
  logic [EXT_LEN:0]     sum;
  logic                 special;
  logic [FLOAT_LEN-1:0] special_val;
  logic                 zero_sign;

  logic                 s2_special;
  logic [FLOAT_LEN-1:0] s2_special_val;
  logic                 s2_sign, s2_zero_sign;
  logic [EXP_LEN-1:0]   s2_exp;
  logic [EXT_LEN:0]     s2_sum;

  logic [3:0]           lz, sh;
  logic [EXP_LEN-1:0]   limit;
  logic [EXT_LEN-1:0]   norm;
  logic [5:0]           ne, fe;
  logic                 round_up;
  logic [SIG_LEN:0]     mant;
  logic [MANT_LEN-1:0]  frac;
  logic                 sign_out;
  logic [FLOAT_LEN-1:0] packed_res;

  // Stage 1: order by magnitude, align, add/subtract magnitudes.
  always_comb begin
    ua        = unpack(a_q);
    ub        = unpack(b_q);
    a_larger  = (a_q[14:0] >= b_q[14:0]);
    big_sign  = a_larger ? ua.sign : ub.sign;
    sml_sign  = a_larger ? ub.sign : ua.sign;
    big_exp   = a_larger ? ua.exp  : ub.exp;
    sml_exp   = a_larger ? ub.exp  : ua.exp;
    big_sig   = a_larger ? ua.sig  : ub.sig;
    sml_sig   = a_larger ? ub.sig  : ua.sig;
    diff      = big_exp - sml_exp;
    big_ext   = {big_sig, 3'b000};
    sml_ext   = {sml_sig, 3'b000};
    sml_shift = sml_ext >> diff;
    lost_mask = ~({EXT_LEN{1'b1}} << diff);
    sticky    = |(sml_ext & lost_mask);
    if (diff >= 5'(EXT_LEN)) aligned = {{(EXT_LEN-1){1'b0}}, |sml_sig};
    else                     aligned = {sml_shift[EXT_LEN-1:1], sml_shift[0] | sticky};
    if (big_sign ^ sml_sign) sum = {1'b0, big_ext} - {1'b0, aligned};
    else                     sum = {1'b0, big_ext} + {1'b0, aligned};
    zero_sign = ua.is_zero & ub.is_zero & ua.sign & ub.sign;

    special     = 1'b1;
    special_val = QNAN;
    if (ua.is_nan || ub.is_nan)                       special_val = QNAN;
    else if (ua.is_inf && ub.is_inf && (ua.sign != ub.sign)) special_val = QNAN;
    else if (ua.is_inf)                               special_val = a_q;
    else if (ub.is_inf)                               special_val = b_q;
    else                                              special = 1'b0;
  end

  float16_lzc u_lzc (
    .value (s2_sum[EXT_LEN-1:0]),
    .count (lz)
  );

  // Stage 2: normalize (left shift never drops exponent below 1), round, pack.
  always_comb begin
    limit = (s2_exp != '0) ? s2_exp - 5'd1 : '0;
    sh    = ({1'b0, lz} < limit) ? lz : 4'(limit);
    if (s2_sum[EXT_LEN]) begin
      norm = {s2_sum[EXT_LEN:2], s2_sum[1] | s2_sum[0]};
      ne   = {1'b0, s2_exp} + 6'd1;
    end else begin
      norm = s2_sum[EXT_LEN-1:0] << sh;
      ne   = {1'b0, s2_exp} - 6'(sh);
    end
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant     = {1'b0, norm[EXT_LEN-1:3]} + 12'(round_up);
    if (mant[SIG_LEN]) begin
      fe   = ne + 6'd1;
      frac = '0;
    end else begin
      fe   = mant[MANT_LEN] ? ne : 6'd0;
      frac = mant[MANT_LEN-1:0];
    end
    sign_out = (s2_sum == '0) ? s2_zero_sign : s2_sign;
    if (s2_special)                packed_res = s2_special_val;
    else if (fe >= 6'(EXP_MAX))    packed_res = sign_out ? NEG_INF : POS_INF;
    else                           packed_res = {sign_out, fe[EXP_LEN-1:0], frac};
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      a_q            <= '0;
      b_q            <= '0;
      s2_special     <= 1'b0;
      s2_special_val <= '0;
      s2_sign        <= 1'b0;
      s2_zero_sign   <= 1'b0;
      s2_exp         <= '0;
      s2_sum         <= '0;
      result         <= '0;
    end else begin
      a_q            <= a;
      b_q            <= b;
      s2_special     <= special;
      s2_special_val <= special_val;
      s2_sign        <= big_sign;
      s2_zero_sign   <= zero_sign;
      s2_exp         <= big_exp;
      s2_sum         <= sum;
      result         <= packed_res;
    end
  end

endmodule

// File: tb/tb_float16_adder.sv
// Scoreboard bench for float16_adder: directed corner cases, reset behaviour and a random stream.
module tb_float16_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a, b, result;

  float16_adder dut (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .result(result));

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] val;
    real         sum;
    bit          chk_real;
    int          id;
  } exp_t;

  exp_t q[$];
  int   total  = 0;
  int   passed = 0;

  function automatic real pow2(input int n);
    real r = 1.0;
    if (n >= 0) repeat (n) r = r * 2.0;
    else        repeat (-n) r = r / 2.0;
    return r;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    int  e = int'(h[14:10]);
    real m;
    if (e == 0) m = real'(int'(h[9:0])) * pow2(-24);
    else        m = real'(int'({1'b1, h[9:0]})) * pow2(e - 25);
    return h[15] ? -m : m;
  endfunction

  // Real to binary16 with round-to-nearest-even.
  function automatic logic [15:0] r2h(input real r);
    logic   s;
    real    x, y, qv, fr;
    int     e;
    longint fl;
    s = (r < 0.0);
    x = s ? -r : r;
    if (x == 0.0) return {s, 15'd0};
    y = x;
    e = 0;
    while (y >= 2.0) begin y = y / 2.0; e++; end
    while (y < 1.0)  begin y = y * 2.0; e--; end
    if (e < -14) qv = x * 16777216.0;
    else         qv = y * 1024.0;
    fl = longint'($floor(qv));
    fr = qv - real'(fl);
    if (fr > 0.5 || (fr == 0.5 && fl[0])) fl++;
    if (e < -14) return {s, 15'(fl)};
    if (fl == 2048) begin fl = 1024; e++; end
    if (e + 15 >= 31) return {s, 5'h1F, 10'd0};
    return {s, 5'(e + 15), 10'(fl)};
  endfunction

  function automatic logic [15:0] model_add(input logic [15:0] x, input logic [15:0] y);
    logic xn, yn, xi, yi;
    real  s;
    xn = (x[14:10] == 5'h1F) && (x[9:0] != 0);
    yn = (y[14:10] == 5'h1F) && (y[9:0] != 0);
    xi = (x[14:0] == 15'h7C00);
    yi = (y[14:0] == 15'h7C00);
    if (xn || yn) return 16'h7E00;
    if (xi && yi) return (x[15] == y[15]) ? x : 16'h7E00;
    if (xi) return x;
    if (yi) return y;
    s = h2r(x) + h2r(y);
    if (s == 0.0) return (x == 16'h8000 && y == 16'h8000) ? 16'h8000 : 16'h0000;
    return r2h(s);
  endfunction

  task automatic check(input exp_t e);
    real got, diff;
    total++;
    assert (result === e.val) passed++;
    else $error("FAIL result id=%0d got=%h want=%h", e.id, result, e.val);
    if (e.chk_real) begin
      got  = h2r(result);
      diff = got - e.sum;
      if (diff < 0.0) diff = -diff;
      total++;
      assert (diff <= 0.2) passed++;
      else $error("FAIL realsum id=%0d got=%f want=%f", e.id, got, e.sum);
    end
  endtask

  // One pair per cycle; output for the pair driven three negedges earlier is checked first.
  task automatic step(input logic [15:0] av, input logic [15:0] bv, input logic [15:0] ev,
                      input real rs, input bit cr, input int id);
    exp_t e;
    @(negedge clk);
    if (q.size() == 3) check(q.pop_front());
    a = av;
    b = bv;
    e.val = ev; e.sum = rs; e.chk_real = cr; e.id = id;
    q.push_back(e);
  endtask

  task automatic do_reset();
    exp_t z;
    @(negedge clk);
    rst_n = 1'b1;
    a = 16'h0;
    b = 16'h0;
    @(negedge clk);
    total++;
    assert (result === 16'h0000) passed++;
    else $error("FAIL reset_clear got=%h want=0000", result);
    q.delete();
    z.val = 16'h0000; z.sum = 0.0; z.chk_real = 1'b0; z.id = -1;
    q.push_back(z);
    q.push_back(z);
    rst_n = 1'b0;
  endtask

  initial begin
    logic [15:0] da[15] = '{16'h3C00, 16'h3E00, 16'h7BFF, 16'h7C00, 16'h7E01, 16'h3C00, 16'h3C01,
                            16'h0001, 16'h0400, 16'h4500, 16'h8000, 16'h0000, 16'h7C00, 16'h3C00, 16'hFBFF};
    logic [15:0] db[15] = '{16'h3C00, 16'hB800, 16'h7BFF, 16'hFC00, 16'h3C00, 16'h1000, 16'h1000,
                            16'h0001, 16'h8001, 16'hC500, 16'h8000, 16'h8000, 16'h4000, 16'hFC00, 16'hFBFF};
    logic [15:0] de[15] = '{16'h4000, 16'h3C00, 16'h7C00, 16'h7E00, 16'h7E00, 16'h3C00, 16'h3C02,
                            16'h0002, 16'h03FF, 16'h0000, 16'h8000, 16'h0000, 16'h7C00, 16'hFC00, 16'hFC00};
    int          ka, kb;
    real         va, vb;
    logic [15:0] ha, hb;

    rst_n = 1'b1;
    a = 16'h0;
    b = 16'h0;
    do_reset();

    for (int i = 0; i < 15; i++) step(da[i], db[i], de[i], 0.0, 1'b0, i);

    for (int i = 0; i < 1000; i++) begin
      if (i == 500) do_reset();
      ka = int'($urandom_range(0, 99999));
      kb = int'($urandom_range(0, 99999));
      va = real'(ka) / 1000.0;
      vb = real'(kb) / 1000.0;
      if ($urandom_range(0, 1) == 1) va = -va;
      if ($urandom_range(0, 1) == 1) vb = -vb;
      ha = r2h(va);
      hb = r2h(vb);
      step(ha, hb, model_add(ha, hb), va + vb, 1'b1, 1000 + i);
    end

    repeat (3) step(16'h0, 16'h0, 16'h0, 0.0, 1'b0, 9999);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/float16_adder.md
FLOAT16_ADDER -- requirements
Module: float16_adder

Interface
REQ-001 SHALL have parameter FLOAT_LEN, default 16, meaning total word width.
REQ-002 SHALL have parameter EXP_LEN, default 5, meaning exponent field width; bias 15.
REQ-003 SHALL have parameter MANT_LEN, default 10, meaning stored fraction width.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous and active-high; asserted when 1, despite the name.
REQ-006 SHALL have port a  input  FLOAT_LEN  IEEE-754 binary16 operand A, sampled every cycle.
REQ-007 SHALL have port b  input  FLOAT_LEN  IEEE-754 binary16 operand B, sampled every cycle.
REQ-008 SHALL have port result  output  FLOAT_LEN  registered binary16 sum a+b.

Function
REQ-009 SHALL compute result = round(a + b) per IEEE-754 binary16, round-to-nearest-ties-to-even, bit-exact.
REQ-010 SHALL be fully pipelined: latency exactly 2 cycles, one new operand pair accepted per cycle, no handshake or stall.
REQ-011 SHALL sample a/b at clock edge N into stage 1 and present the sum on result after edge N+2.
REQ-012 Stage 1 SHALL: unpack, insert hidden bit (0 for exponent 0, effective exponent 1), swap so the larger magnitude is first, align the smaller by exponent difference keeping guard, round and sticky bits, then add or subtract magnitudes.
REQ-013 Shift amounts of 14 or more SHALL reduce the smaller operand to its sticky bit only.
REQ-014 Stage 2 SHALL: normalize using a leading-zero count (left shift) or carry (right shift by 1), round, and pack.
REQ-015 Rounding carry-out of the fraction SHALL increment the exponent. Reaching exponent 31 SHALL give infinity with fraction 0.
REQ-016 Results below the normal range SHALL be produced as subnormals, exponent 0. Subnormal inputs SHALL be handled exactly.
REQ-017 Overflow SHALL produce signed infinity: 0x7C00 or 0xFC00.
REQ-018 Any NaN input SHALL produce canonical quiet NaN 0x7E00.
REQ-019 (+inf)+(-inf) SHALL produce 0x7E00.
REQ-020 inf plus finite SHALL produce that inf.
REQ-021 An exact-zero result of opposite-sign operands SHALL be +0 (0x0000).
REQ-022 (-0)+(-0) SHALL be 0x8000. (+0)+(-0) SHALL be 0x0000.
REQ-023 Sign of a nonzero result SHALL be the sign of the larger-magnitude operand.
REQ-024 Equal magnitudes with opposite signs SHALL yield +0.

Reset
REQ-025 While rst_n=1 at a rising edge, all pipeline registers SHALL clear and result SHALL be 0x0000 from the next cycle.
REQ-026 Reset mid-stream SHALL discard in-flight operations.
REQ-027 After reset deasserts, the first valid result SHALL appear 2 cycles after the first sampled pair; result stays 0x0000 until then.

Structure
REQ-028 Package float16_pkg SHALL hold FLOAT_LEN, EXP_LEN, MANT_LEN, BIAS=15, QNAN=16'h7E00, POS_INF/NEG_INF, and the unpacked-operand struct typedef.
REQ-029 The struct typedef SHALL contain sign, exponent, significand with hidden bit, and is_nan/is_inf/is_zero flags.
REQ-030 Leading-zero counter SHALL be a separate sub-module float16_lzc (14-bit input, 4-bit count), used in stage 2.
REQ-031 All else SHALL reside in float16_adder.

Verification
REQ-032 Bench SHALL cover: 0x3C00 + 0x3C00 -> 0x4000 after 2 cycles; 0x3E00 + 0xB800 -> 0x3C00.
REQ-033 Bench SHALL cover: 0x7BFF + 0x7BFF -> 0x7C00; 0x7C00 + 0xFC00 -> 0x7E00; 0x7E01 + 0x3C00 -> 0x7E00.
REQ-034 Bench SHALL cover: 0x3C00 + 0x1000 -> 0x3C00 (tie rounds to even); 0x3C01 + 0x1000 -> 0x3C02.
REQ-035 Bench SHALL cover: 0x0001 + 0x0001 -> 0x0002; 0x0400 + 0x8001 -> 0x03FF; 0x4500 + 0xC500 -> 0x0000.
REQ-036 Bench SHALL cover 1000 back-to-back random pairs, each operand ±(0..99.999 step 0.001) converted with RNE, fed one pair per cycle after reset.
REQ-037 In that random test, every result SHALL be bit-exact vs. a software binary16 model 2 cycles later, and within 0.2 of the real-valued sum.
REQ-038 Bench SHALL assert reset during the stream and check result=0x0000 the next cycle, then correct results 2 cycles after restart.
